// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and constants for the nibble-serial adder/subtractor
// and the 4-bit addsub slice it drives.
//   NIBBLE_W   width of one slice
//   state_t    sequencer states
//   OP_ADD/SUB operation encodings on the op inputs
package addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Two's-complement overflow from operand and result sign bits.
    // Subtract overflows when the signs differ and the result sign leaves A's sign.
    function automatic logic signed_ovf(input logic op, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
        logic same_sign;
        same_sign = (a_msb == b_msb);
        if (op == OP_SUB)
            return !same_sign && (r_msb != a_msb);
        else
            return same_sign && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub.sv
// addsub: 4-bit add/subtract slice.
//   a, b   in  4  operand nibbles
//   xin    in  1  carry-in (add) / borrow-in (sub)
//   op     in  1  OP_ADD: a+b+xin, OP_SUB: a-b-xin
//   s_d    out 4  sum / difference nibble
//   co_bo  out 1  carry-out (add) / borrow-out (sub)
module addsub
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                xin,
    input  logic                op,
    output logic [NIBBLE_W-1:0] s_d,
    output logic                co_bo
);

    logic [NIBBLE_W:0] t;

    // One extra bit: for add it is the carry, for subtract the result range is
    // -16..15, so the extra bit is set exactly when the difference went negative.
    always_comb begin
        t = '0;
        if (op == OP_SUB)
            t = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, xin};
        else
            t = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, xin};
    end

    assign s_d   = t[NIBBLE_W-1:0];
    assign co_bo = t[NIBBLE_W];

endmodule

// File: rtl/addsub_serial16.sv
// addsub_serial16: nibble-serial multi-word adder/subtractor built around one
// 4-bit addsub slice; carry/borrow is chained LSB-first through a register.
//   clk, rst_n   clock, synchronous active-low reset
//   start        request, sampled while busy=0 (IDLE or DONE)
//   op, xin      operation and carry/borrow-in, latched on accepted start
//   a, b         W-bit operands, latched on accepted start
//   busy         high while nibbles are being processed
//   done         one-cycle pulse, result/co_bo/ovf valid
//   result       W-bit sum/difference, updated when entering DONE
//   co_bo        carry-out / borrow-out of the top nibble
//   ovf          two's-complement signed overflow
module addsub_serial16
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     op,
    input  logic                     xin,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    output logic                     busy,
    output logic                     done,
    output logic [NIBBLE_W*NIBBLES-1:0] result,
    output logic                     co_bo,
    output logic                     ovf
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    state_t              state, nxt;
    logic [W-1:0]        a_sh, b_sh, acc;
    logic [W-1:0]        result_q;
    logic                op_q, cy, co_q, ovf_q;
    logic [CNT_W-1:0]    cnt;

    logic                accept_idle, overlap, last;
    logic [NIBBLE_W-1:0] sl_a, sl_b, sl_s;
    logic                sl_x, sl_op, sl_co;

    // A start held through DONE is processed immediately: the slice takes
    // nibble 0 straight from the input pins during the DONE cycle, so
    // back-to-back operations complete every NIBBLES cycles.
    assign accept_idle = (state == IDLE) && start;
    assign overlap     = (state == DONE) && start;
    assign last        = (state == RUN) && (cnt == CNT_LAST);

    always_comb begin
        sl_a  = a_sh[NIBBLE_W-1:0];
        sl_b  = b_sh[NIBBLE_W-1:0];
        sl_x  = cy;
        sl_op = op_q;
        if (overlap) begin
            sl_a  = a[NIBBLE_W-1:0];
            sl_b  = b[NIBBLE_W-1:0];
            sl_x  = xin;
            sl_op = op;
        end
    end

    addsub u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .xin   (sl_x),
        .op    (sl_op),
        .s_d   (sl_s),
        .co_bo (sl_co)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (last)  nxt = DONE;
            DONE:    nxt = start ? RUN : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            op_q     <= OP_ADD;
            cy       <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state <= nxt;
            if (accept_idle) begin
                a_sh <= a;
                b_sh <= b;
                op_q <= op;
                cy   <= xin;
                cnt  <= '0;
                acc  <= '0;
            end else if (overlap) begin
                // Nibble 0 already consumed this cycle.
                a_sh <= a >> NIBBLE_W;
                b_sh <= b >> NIBBLE_W;
                op_q <= op;
                cy   <= sl_co;
                cnt  <= CNT_W'(1);
                acc  <= {sl_s, {(W-NIBBLE_W){1'b0}}};
            end else if (state == RUN) begin
                a_sh <= a_sh >> NIBBLE_W;
                b_sh <= b_sh >> NIBBLE_W;
                cy   <= sl_co;
                cnt  <= cnt + 1'b1;
                acc  <= {sl_s, acc[W-1:NIBBLE_W]};
                if (last) begin
                    // Top nibble in flight: its operand MSBs are still in the
                    // low nibble of the shift registers.
                    result_q <= {sl_s, acc[W-1:NIBBLE_W]};
                    co_q     <= sl_co;
                    ovf_q    <= signed_ovf(op_q, a_sh[NIBBLE_W-1],
                                           b_sh[NIBBLE_W-1], sl_s[NIBBLE_W-1]);
                end
            end
        end
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign result = result_q;
    assign co_bo  = co_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_serial16.sv
module tb_addsub_serial16;
    import addsub_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         xin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, co_bo, ovf;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    addsub_serial16 #(.NIBBLES(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .xin    (xin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .co_bo  (co_bo),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full-width reference arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic o, input logic ci);
        logic [W:0] t;
        exp_t m;
        if (o) t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
        else   t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        m.r = t[W-1:0];
        m.c = t[W];
        if (o) m.v = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
        else   m.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return m;
    endfunction

    // Scoreboard check on every done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic had;
            exp_t e;
            n_done++;
            had = (sb.size() != 0);
            chk("done_expected", W'(had), W'(1'b1));
            if (had) begin
                e = sb.pop_front();
                chk("result", result, e.r);
                chk("co_bo", W'(co_bo), W'(e.c));
                chk("ovf", W'(ovf), W'(e.v));
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic o, input logic ci, input bit push);
        a = x; b = y; op = o; xin = ci; start = 1'b1;
        if (push) sb.push_back(model(x, y, o, ci));
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Counts edges until done, checking busy along the way.
    task automatic wait_done(input int lat, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
            if (!done) chk({tag, "_busy"}, W'(busy), W'(1'b1));
        end while (!done && n < 20);
        chk({tag, "_latency"}, W'(n), W'(lat));
        chk({tag, "_busy_at_done"}, W'(busy), W'(1'b0));
    endtask

    task automatic single(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic o, input logic ci, input string tag);
        issue(x, y, o, ci, 1'b1);
        step();
        start = 1'b0;
        chk({tag, "_busy_e0"}, W'(busy), W'(1'b1));
        wait_done(N, tag);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        logic [W-1:0] held;

        // Reset
        step(); step();
        chk("rst_busy", W'(busy), W'(1'b0));
        chk("rst_done", W'(done), W'(1'b0));
        chk("rst_result", result, '0);
        chk("rst_co_bo", W'(co_bo), W'(1'b0));
        chk("rst_ovf", W'(ovf), W'(1'b0));
        rst_n = 1'b1;
        step();

        // Add with nibble carries
        single(16'h1234, 16'h0FFF, OP_ADD, 1'b0, "add_nib");
        chk("add_nib_hold", result, 16'h2233);

        // Back-to-back: second start held through DONE
        issue(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 1'b1);
        step();
        chk("b2b_busy_e0", W'(busy), W'(1'b1));
        issue(16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1'b1);
        wait_done(N, "b2b_first");
        step();
        start = 1'b0;
        chk("b2b_busy_accept", W'(busy), W'(1'b1));
        // one edge already elapsed since the first done: total gap N
        wait_done(N - 1, "b2b_second");
        step();

        // Subtract
        single(16'h0005, 16'h0007, OP_SUB, 1'b0, "sub_borrow");
        single(16'h8000, 16'h0001, OP_SUB, 1'b0, "sub_ovf");
        single(16'h0010, 16'h0000, OP_SUB, 1'b1, "sub_bin");
        single(16'h0000, 16'h0000, OP_ADD, 1'b1, "add_cin");

        // Start while busy is ignored
        d0 = n_done;
        issue(16'h0100, 16'h0020, OP_ADD, 1'b0, 1'b1);
        step();
        start = 1'b0;
        step();
        a = 16'h1111; b = 16'h1111; start = 1'b1;
        step();
        start = 1'b0; a = 16'h2222; b = 16'h3333;
        for (int i = 0; i < 10 && !done; i++) step();
        for (int i = 0; i < 6; i++) step();
        chk("busy_start_one_done", W'(n_done - d0), W'(1));
        chk("busy_start_result_held", result, 16'h0120);
        chk("busy_start_idle", W'(busy), W'(1'b0));

        // Reset mid-operation
        d0 = n_done;
        held = result;
        chk("pre_rst_result_nonzero", W'(held != '0), W'(1'b1));
        issue(16'h1234, 16'h4321, OP_ADD, 1'b0, 1'b0);
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", W'(busy), W'(1'b0));
        chk("midrst_done", W'(done), W'(1'b0));
        chk("midrst_result", result, '0);
        chk("midrst_co_bo", W'(co_bo), W'(1'b0));
        chk("midrst_ovf", W'(ovf), W'(1'b0));
        for (int i = 0; i < 6; i++) step();
        chk("midrst_no_done", W'(n_done - d0), W'(0));
        single(16'hA5A5, 16'h5A5B, OP_ADD, 1'b0, "post_rst");
        single(16'h1000, 16'h2000, OP_SUB, 1'b0, "post_rst_sub");

        chk("scoreboard_drained", W'(sb.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
